// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HOLD_CYCLES-wide levels with a GAP_CYCLES low gap between them.
// Define PULSE_STRETCHER_RETRIGGER_EN to make strobes retrigger the hold instead of being queued.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3,
    localparam int PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pulse_in,
    input  logic          clear_ovf,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);
    // state | meaning
    // IDLE  | output low, nothing queued
    // HOLD  | level_out high, counter runs the hold time
    // GAP   | level_out low, counter runs the minimum gap
    localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW    = $clog2(MAXHG + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic            level_q, busy_q;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = '0;
        ovf_d   = ovf_q & ~clear_ovf;
        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (pulse_in) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic inc, dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q & ~clear_ovf;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    dec     = 1'b1;
                    inc     = pulse_in;
                end else if (pulse_in) begin
                    // strobe consumed directly, never enters the queue
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                inc = pulse_in;
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (pend_q != '0) begin
                        cnt_d = HOLD_LOAD;
                        dec   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                inc = pulse_in;
                if (cnt_q == '0) begin
                    if (pend_q != '0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        dec     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // set beats clear when an event is lost on the clearing edge
        if (inc && !dec) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else                    pend_d = pend_q + PW'(1);
        end else if (dec && !inc) begin
            pend_d = pend_q - PW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: timeline reference model plus directed and random scenarios.
module tb_pulse_stretcher;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int MP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pulse_in = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       level_out, busy, overflow;
    logic [1:0] pending;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .clear_ovf(clear_ovf),
        .level_out(level_out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: each level is described only by the edge at which it started (m_last).
    int edge_no, m_last, m_pend, m_ovf, m_level, m_busy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_no = 0; m_last = -1000; m_pend = 0; m_ovf = 0;
        end else begin
            int inc, dec, lost;
            edge_no++;
            inc = 0; dec = 0; lost = 0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
            if (pulse_in) m_last = edge_no;
`else
            if (edge_no - m_last > H + G) begin
                if (m_pend > 0) begin
                    dec = 1; inc = int'(pulse_in); m_last = edge_no;
                end else if (pulse_in) begin
                    m_last = edge_no;
                end
            end else begin
                inc = int'(pulse_in);
                if (edge_no - m_last == H + G && m_pend > 0) begin
                    dec = 1; m_last = edge_no;
                end
            end
            if (inc == 1 && dec == 0 && m_pend == MP) lost = 1;
            else m_pend = m_pend + inc - dec;
`endif
            if (clear_ovf) m_ovf = 0;
            if (lost == 1) m_ovf = 1;
        end
        m_level = (edge_no - m_last < H) ? 1 : 0;
        m_busy  = (edge_no - m_last < H + G) ? 1 : 0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (int'(level_out) != m_level || int'(busy) != m_busy ||
                int'(pending) != m_pend || int'(overflow) != m_ovf) begin
                errors++;
                $display("FAIL cycle_compare t=%0t edge=%0d dut l/b/p/o=%0b/%0b/%0d/%0b required=%0d/%0d/%0d/%0d",
                         $time, edge_no, level_out, busy, pending, overflow, m_level, m_busy, m_pend, m_ovf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int mdl, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t dut=%0d required=%0d", name, $time, act, exp);
        end
        checks++;
        if (mdl != exp) begin
            errors++;
            $display("FAIL %s_model t=%0t model=%0d required=%0d", name, $time, mdl, exp);
        end
    endtask

    task automatic tick(input logic p, input logic c);
        pulse_in = p;
        clear_ovf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_in = i[0];
            @(posedge clk);
            #1;
        end
        pulse_in = 1'b0;
        chk("rst_level", int'(level_out), m_level, 0);
        chk("rst_busy", int'(busy), m_busy, 0);
        chk("rst_pending", int'(pending), m_pend, 0);
        chk("rst_overflow", int'(overflow), m_ovf, 0);
        reset = 1'b1;
    endtask

    initial begin
        int rises;
        logic prev;
        @(posedge clk);
        cmp_en = 1'b1;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            tick(k == 10 || k == 12, 1'b0);
            if (k >= 10 && k <= 15) chk("retrig_level_hi", int'(level_out), m_level, 1);
            if (k == 16) chk("retrig_level_lo", int'(level_out), m_level, 0);
            chk("retrig_pending", int'(pending), m_pend, 0);
            chk("retrig_overflow", int'(overflow), m_ovf, 0);
        end
`else
        // reset behaviour
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b0);
            chk("post_rst_level", int'(level_out), m_level, 0);
            chk("post_rst_busy", int'(busy), m_busy, 0);
        end

        // single event
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick(k == 10, 1'b0);
            if (k >= 10 && k <= 13) chk("single_level_hi", int'(level_out), m_level, 1);
            if (k == 14) chk("single_level_lo", int'(level_out), m_level, 0);
            if (k == 15) chk("single_busy_hi", int'(busy), m_busy, 1);
            if (k == 16) chk("single_busy_lo", int'(busy), m_busy, 0);
            chk("single_pending", int'(pending), m_pend, 0);
        end

        // burst of three
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            tick(k >= 10 && k <= 12, 1'b0);
            if (k == 11) chk("burst_pend1", int'(pending), m_pend, 1);
            if (k == 12) chk("burst_pend2", int'(pending), m_pend, 2);
            if (k == 10 || k == 16 || k == 22) chk("burst_rise", int'(level_out), m_level, 1);
            if (k == 9 || k == 15 || k == 21 || k == 26) chk("burst_low", int'(level_out), m_level, 0);
            if (k == 22) chk("burst_pend0", int'(pending), m_pend, 0);
            if (k == 27) chk("burst_busy_hi", int'(busy), m_busy, 1);
            if (k == 28) chk("burst_busy_lo", int'(busy), m_busy, 0);
        end

        // overflow
        do_reset();
        rises = 0;
        prev = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick(k >= 10 && k <= 14, k == 40);
            if (level_out && !prev) rises++;
            prev = level_out;
            if (k == 13) chk("ovf_pend_sat", int'(pending), m_pend, 3);
            if (k == 13) chk("ovf_not_yet", int'(overflow), m_ovf, 0);
            if (k == 14) chk("ovf_set", int'(overflow), m_ovf, 1);
            if (k == 39) chk("ovf_sticky", int'(overflow), m_ovf, 1);
            if (k == 40) chk("ovf_cleared", int'(overflow), m_ovf, 0);
        end
        checks++;
        if (rises != 4) begin
            errors++;
            $display("FAIL ovf_level_count dut=%0d required=4", rises);
        end

        // async reset during the second hold
        do_reset();
        for (int k = 1; k <= 18; k++) tick(k >= 10 && k <= 12, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_level", int'(level_out), m_level, 0);
        chk("midrst_pending", int'(pending), m_pend, 0);
        chk("midrst_busy", int'(busy), m_busy, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 1'b0);
            chk("midrst_quiet", int'(level_out), m_level, 0);
        end
`endif

        // random traffic at several densities, with occasional async resets
        for (int run = 0; run < 4; run++) begin
            int prob;
            prob = (run == 0) ? 10 : (run == 1) ? 30 : (run == 2) ? 60 : 90;
            do_reset();
            for (int k = 0; k < 400; k++) begin
                tick($urandom_range(99) < prob, $urandom_range(39) == 0);
                if ($urandom_range(199) == 0) begin
                    #2 reset = 1'b0;
                    #1;
                    chk("rand_async_rst", int'(level_out), m_level, 0);
                    reset = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
